// File: rtl/strobe_period_monitor_if.sv
// Strobe source to period monitor bundle: one strobe line out, lock/error status back.
interface strobe_period_monitor_if #(
    parameter int unsigned CW = 25
);
    logic          strobe_in;
    logic          locked;
    logic          period_err;
    logic          timeout;
    logic [CW-1:0] last_period;
    logic [7:0]    err_count;

    modport master (
        output strobe_in,
        input  locked,
        input  period_err,
        input  timeout,
        input  last_period,
        input  err_count
    );

    modport slave (
        input  strobe_in,
        output locked,
        output period_err,
        output timeout,
        output last_period,
        output err_count
    );
endinterface

// File: rtl/strobe_period_monitor.sv
// Measures strobe-to-strobe intervals, locks after LOCK_COUNT in-window periods,
// and flags early/late/missing strobes with a saturating error counter.
module strobe_period_monitor #(
    parameter int unsigned EXPECTED_PERIOD = 24000000,
    parameter int unsigned TOLERANCE       = 2,
    parameter int unsigned LOCK_COUNT      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    strobe_period_monitor_if.slave  bus
);
    localparam int unsigned CW = $clog2(EXPECTED_PERIOD + TOLERANCE + 2);
    localparam int unsigned GW = $clog2(LOCK_COUNT + 1);
    localparam logic [CW-1:0] WinMin  = CW'(EXPECTED_PERIOD - TOLERANCE);
    localparam logic [CW-1:0] WinMax  = CW'(EXPECTED_PERIOD + TOLERANCE);
    localparam logic [GW-1:0] GoodTop = GW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StMeasure, StLocked} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic          locked_q, locked_d;
    logic          period_err_q, period_err_d;
    logic          timeout_q, timeout_d;
    logic [CW-1:0] last_period_q, last_period_d;
    logic [7:0]    err_count_q, err_count_d;

    logic in_window;
    logic [7:0] err_count_inc;

    assign in_window     = (cnt_q >= WinMin) && (cnt_q <= WinMax);
    assign err_count_inc = (err_count_q == 8'hff) ? err_count_q : err_count_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        good_cnt_d    = good_cnt_q;
        locked_d      = locked_q;
        period_err_d  = 1'b0;
        timeout_d     = 1'b0;
        last_period_d = last_period_q;
        err_count_d   = err_count_q;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (bus.strobe_in) begin
                    state_d    = StMeasure;
                    cnt_d      = CW'(1);
                    good_cnt_d = '0;
                end
            end
            StMeasure, StLocked: begin
                // A strobe coinciding with cnt==WinMax is in-window, so it wins over timeout.
                if (bus.strobe_in) begin
                    cnt_d         = CW'(1);
                    last_period_d = cnt_q;
                    if (!in_window) begin
                        period_err_d = 1'b1;
                        err_count_d  = err_count_inc;
                        good_cnt_d   = '0;
                        locked_d     = 1'b0;
                        state_d      = StMeasure;
                    end else if (state_q == StMeasure) begin
                        if (good_cnt_q == GoodTop) begin
                            state_d  = StLocked;
                            locked_d = 1'b1;
                        end else begin
                            good_cnt_d = good_cnt_q + GW'(1);
                        end
                    end
                end else if (cnt_q == WinMax) begin
                    timeout_d   = 1'b1;
                    err_count_d = err_count_inc;
                    locked_d    = 1'b0;
                    good_cnt_d  = '0;
                    cnt_d       = '0;
                    state_d     = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            good_cnt_q    <= '0;
            locked_q      <= 1'b0;
            period_err_q  <= 1'b0;
            timeout_q     <= 1'b0;
            last_period_q <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            good_cnt_q    <= good_cnt_d;
            locked_q      <= locked_d;
            period_err_q  <= period_err_d;
            timeout_q     <= timeout_d;
            last_period_q <= last_period_d;
            err_count_q   <= err_count_d;
        end
    end

    assign bus.locked      = locked_q;
    assign bus.period_err  = period_err_q;
    assign bus.timeout     = timeout_q;
    assign bus.last_period = last_period_q;
    assign bus.err_count   = err_count_q;
endmodule

// File: tb/tb_strobe_period_monitor.sv
// Directed bench for strobe_period_monitor with EXPECTED_PERIOD=10, TOLERANCE=1, LOCK_COUNT=3.
module tb_strobe_period_monitor;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    strobe_period_monitor_if #(.CW(4)) bus ();

    strobe_period_monitor #(
        .EXPECTED_PERIOD(10),
        .TOLERANCE      (1),
        .LOCK_COUNT     (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge with the given strobe level; outputs sampled 1 time unit later.
    task automatic step(input logic s);
        bus.strobe_in = s;
        @(posedge clk);
        #1;
        bus.strobe_in = 1'b0;
    endtask

    // Strobe arriving n cycles after the previous one.
    task automatic gap(input int n);
        for (int i = 0; i < n - 1; i++) step(1'b0);
        step(1'b1);
    endtask

    initial begin
        int seen_timeout;
        int missed_err;
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.strobe_in = 1'b0;

        // Asynchronous reset between edges
        #2 reset = 1'b0;
        #1;
        chk("rst_locked", 32'(bus.locked), 0);
        chk("rst_perr", 32'(bus.period_err), 0);
        chk("rst_tmo", 32'(bus.timeout), 0);
        chk("rst_last", 32'(bus.last_period), 0);
        chk("rst_errc", 32'(bus.err_count), 0);
        @(negedge clk);
        reset = 1'b1;

        // Idle without strobes: nothing happens
        seen_timeout = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b0);
            if (bus.timeout !== 1'b0 || bus.locked !== 1'b0) seen_timeout++;
        end
        chk("idle_quiet", 32'(seen_timeout), 0);
        chk("idle_errc", 32'(bus.err_count), 0);

        // Lock: first strobe starts measuring, three good periods lock
        step(1'b1);
        gap(10);
        gap(10);
        chk("lock_pre", 32'(bus.locked), 0);
        gap(10);
        chk("lock_on", 32'(bus.locked), 1);
        chk("lock_last", 32'(bus.last_period), 10);
        chk("lock_errc", 32'(bus.err_count), 0);

        // Window edges stay locked
        gap(9);
        chk("win9_locked", 32'(bus.locked), 1);
        chk("win9_perr", 32'(bus.period_err), 0);
        gap(11);
        chk("win11_locked", 32'(bus.locked), 1);
        chk("win11_perr", 32'(bus.period_err), 0);
        chk("win11_last", 32'(bus.last_period), 11);
        gap(9);
        chk("win9b_last", 32'(bus.last_period), 9);
        chk("win9b_locked", 32'(bus.locked), 1);

        // Late strobe: timeout fires after cnt reaches 11
        for (int i = 0; i < 10; i++) step(1'b0);
        chk("late_notmo_yet", 32'(bus.timeout), 0);
        chk("late_locked_yet", 32'(bus.locked), 1);
        step(1'b0);
        chk("late_tmo", 32'(bus.timeout), 1);
        chk("late_locked", 32'(bus.locked), 0);
        chk("late_errc", 32'(bus.err_count), 1);
        chk("late_last", 32'(bus.last_period), 9);
        step(1'b1);
        chk("late_tmo_pulse", 32'(bus.timeout), 0);
        chk("late_restart_perr", 32'(bus.period_err), 0);
        chk("late_restart_errc", 32'(bus.err_count), 1);

        // Relock, then an early strobe
        gap(10);
        gap(10);
        gap(10);
        chk("relock1", 32'(bus.locked), 1);
        gap(8);
        chk("early_perr", 32'(bus.period_err), 1);
        chk("early_locked", 32'(bus.locked), 0);
        chk("early_last", 32'(bus.last_period), 8);
        chk("early_errc", 32'(bus.err_count), 2);
        step(1'b0);
        chk("early_perr_pulse", 32'(bus.period_err), 0);
        gap(9);
        gap(10);
        chk("early_relock_pre", 32'(bus.locked), 0);
        gap(10);
        chk("early_relock", 32'(bus.locked), 1);

        // Missing strobe
        for (int i = 0; i < 10; i++) step(1'b0);
        chk("miss_notmo_yet", 32'(bus.timeout), 0);
        step(1'b0);
        chk("miss_tmo", 32'(bus.timeout), 1);
        chk("miss_locked", 32'(bus.locked), 0);
        chk("miss_perr", 32'(bus.period_err), 0);
        step(1'b0);
        chk("miss_tmo_pulse", 32'(bus.timeout), 0);
        chk("miss_errc", 32'(bus.err_count), 3);
        step(1'b1);
        gap(10);
        gap(10);
        chk("miss_relock_pre", 32'(bus.locked), 0);
        gap(10);
        chk("miss_relock", 32'(bus.locked), 1);
        chk("miss_relock_errc", 32'(bus.err_count), 3);

        // Saturation: every 5-cycle interval is bad
        missed_err = 0;
        for (int i = 0; i < 300; i++) begin
            gap(5);
            if (bus.period_err !== 1'b1) missed_err++;
            if (i == 250) chk("sat_254", 32'(bus.err_count), 254);
            if (i == 251) chk("sat_255", 32'(bus.err_count), 255);
        end
        chk("sat_perr_each", 32'(missed_err), 0);
        chk("sat_hold", 32'(bus.err_count), 255);
        chk("sat_locked", 32'(bus.locked), 0);

        // Relock, then reset mid-lock
        gap(10);
        gap(10);
        gap(10);
        chk("sat_relock", 32'(bus.locked), 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_locked", 32'(bus.locked), 0);
        chk("mid_rst_errc", 32'(bus.err_count), 0);
        chk("mid_rst_last", 32'(bus.last_period), 0);
        @(negedge clk);
        reset = 1'b1;
        step(1'b0);
        chk("post_rst_locked", 32'(bus.locked), 0);
        chk("post_rst_errc", 32'(bus.err_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
